// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in from ID/EXE, stall/flush/divider controls out.
interface pipe_hazard_ctrl_if #(
    parameter int REGFILE_BITS = 5,
    parameter int CNT_WIDTH    = 32
);
    logic [REGFILE_BITS-1:0] id_rs1;
    logic [REGFILE_BITS-1:0] id_rs2;
    logic                    id_use_rs1;
    logic                    id_use_rs2;
    logic                    id_jump;
    logic [REGFILE_BITS-1:0] exe_rd;
    logic                    exe_wr_en;
    logic                    exe_is_load;
    logic                    exe_div_valid;
    logic                    exe_branch_tkn;
    logic                    stall_if;
    logic                    stall_id;
    logic                    hold_exe;
    logic                    flush_id;
    logic                    flush_exe;
    logic                    div_start;
    logic                    div_res_valid;
    logic [CNT_WIDTH-1:0]    stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jump,
               exe_rd, exe_wr_en, exe_is_load, exe_div_valid, exe_branch_tkn,
        input  stall_if, stall_id, hold_exe, flush_id, flush_exe,
               div_start, div_res_valid, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jump,
               exe_rd, exe_wr_en, exe_is_load, exe_div_valid, exe_branch_tkn,
        output stall_if, stall_id, hold_exe, flush_id, flush_exe,
               div_start, div_res_valid, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller: divider sequencing, load-use stalls, control-flow flushes,
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int DIV_LATENCY  = 17,
    parameter int REGFILE_BITS = 5,
    parameter int CNT_WIDTH    = 32
) (
    input  logic              clk,
    input  logic              nrst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int            CW       = $clog2(DIV_LATENCY);
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    rst_q;
    logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
    logic [REGFILE_BITS-1:0] rd;
    logic                    load_use;
    logic                    div_hold;

    assign rd       = bus.exe_rd;
    assign load_use = bus.exe_is_load & bus.exe_wr_en & (rd != '0) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == rd)));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rst_q       <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_q       <= 1'b0;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The cycle right after reset is kept quiet so a divide still asserted upstream
    // cannot start until the pipeline has settled.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        div_hold          = 1'b0;
        bus.stall_if      = 1'b0;
        bus.stall_id      = 1'b0;
        bus.hold_exe      = 1'b0;
        bus.flush_id      = 1'b0;
        bus.flush_exe     = 1'b0;
        bus.div_start     = 1'b0;
        bus.div_res_valid = 1'b0;
        if (!rst_q) begin
            unique case (state_q)
                IDLE: if (bus.exe_div_valid) begin
                    state_d       = RUN;
                    cnt_d         = CNT_INIT;
                    bus.div_start = 1'b1;
                    div_hold      = 1'b1;
                end
                RUN: if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CW'(1);
                    div_hold = 1'b1;
                end else begin
                    state_d           = IDLE;
                    bus.div_res_valid = 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if (div_hold) begin
                bus.hold_exe = 1'b1;
                bus.stall_if = 1'b1;
                bus.stall_id = 1'b1;
            end else if (bus.exe_branch_tkn) begin
                bus.flush_id  = 1'b1;
                bus.flush_exe = 1'b1;
            end else if (load_use) begin
                bus.stall_if  = 1'b1;
                bus.stall_id  = 1'b1;
                bus.flush_exe = 1'b1;
            end else if (bus.id_jump) begin
                bus.flush_id = 1'b1;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (bus.stall_if && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    assign bus.stall_cnt = stall_cnt_q;

    a_no_branch_in_hold: assert property (@(posedge clk) disable iff (!nrst)
        !(bus.hold_exe && bus.exe_branch_tkn));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DIV_LATENCY=4) plus a narrow-counter instance for saturation.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic nrst;
    int   errors = 0;
    int   checks = 0;

    pipe_hazard_ctrl_if #(.REGFILE_BITS(5), .CNT_WIDTH(32)) b ();
    pipe_hazard_ctrl_if #(.REGFILE_BITS(5), .CNT_WIDTH(3))  s ();

    pipe_hazard_ctrl #(.DIV_LATENCY(4), .REGFILE_BITS(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .bus(b));
    pipe_hazard_ctrl #(.DIV_LATENCY(4), .REGFILE_BITS(5), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .nrst(nrst), .bus(s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, hold_exe, flush_id, flush_exe, div_start, div_res_valid}
    function automatic logic [6:0] obs();
        return {b.stall_if, b.stall_id, b.hold_exe, b.flush_id, b.flush_exe,
                b.div_start, b.div_res_valid};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ld, wr, input logic [4:0] rd, r1, r2,
                          input logic u1, u2, jmp, br, dv);
        b.exe_is_load = ld;  b.exe_wr_en = wr;  b.exe_rd = rd;
        b.id_rs1 = r1;  b.id_rs2 = r2;  b.id_use_rs1 = u1;  b.id_use_rs2 = u2;
        b.id_jump = jmp;  b.exe_branch_tkn = br;  b.exe_div_valid = dv;
    endtask

    task automatic clear_inputs();
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        s.exe_is_load = 0;  s.exe_wr_en = 0;  s.exe_rd = 0;  s.id_rs1 = 0;  s.id_rs2 = 0;
        s.id_use_rs1 = 0;  s.id_use_rs2 = 0;  s.id_jump = 0;  s.exe_branch_tkn = 0;
        s.exe_div_valid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        set_in(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        #1;
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL rst_outs: got %b want %b", obs(), 7'b0);
        end
        checks++;
        if (b.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_cnt: got %0d want 0", b.stall_cnt);
        end
        cyc();
        checks++;
        if (obs() !== 7'b1100100) begin
            errors++; $display("FAIL rst_first_lu: got %b want %b", obs(), 7'b1100100);
        end
        cyc();
        checks++;
        if (b.stall_cnt !== 32'd1) begin
            errors++; $display("FAIL rst_cnt1: got %0d want 1", b.stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0); #1; checks++;
        if (obs() !== 7'b1100100) begin
            errors++; $display("FAIL lu_rs1: got %b want %b", obs(), 7'b1100100);
        end
        cyc();
        set_in(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0); #1; checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL lu_rd0: got %b want %b", obs(), 7'b0);
        end
        cyc();
        set_in(1, 1, 5'd7, 5'd3, 5'd7, 1, 1, 0, 0, 0); #1; checks++;
        if (obs() !== 7'b1100100) begin
            errors++; $display("FAIL lu_rs2: got %b want %b", obs(), 7'b1100100);
        end
        cyc();
        set_in(1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0); #1; checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL lu_nouse: got %b want %b", obs(), 7'b0);
        end
        cyc();
        set_in(1, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0); #1; checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL lu_nowr: got %b want %b", obs(), 7'b0);
        end
        cyc();
        set_in(0, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0); #1; checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL lu_noload: got %b want %b", obs(), 7'b0);
        end
        cyc();
        set_in(1, 1, 5'd9, 5'd0, 5'd9, 0, 1, 1, 0, 0); #1; checks++;
        if (obs() !== 7'b1100100) begin
            errors++; $display("FAIL lu_jump: got %b want %b", obs(), 7'b1100100);
        end
        cyc();
        clear_inputs(); #1; checks++;
        if (b.stall_cnt !== 32'd3) begin
            errors++; $display("FAIL lu_cnt: got %0d want 3", b.stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, (c == 2 || c == 7), 0, 1);
            #1;
            if (c == 0 || c == 5)      exp = 7'b1110010;
            else if (c == 4 || c == 9) exp = 7'b0000001;
            else                       exp = 7'b1110000;
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL div_c%0d: got %b want %b", c, obs(), exp);
            end
            if (c == 4) begin
                checks++;
                if (b.stall_cnt !== 32'd4) begin
                    errors++; $display("FAIL div_cnt4: got %0d want 4", b.stall_cnt);
                end
            end
            if (c == 9) begin
                checks++;
                if (b.stall_cnt !== 32'd8) begin
                    errors++; $display("FAIL div_cnt8: got %0d want 8", b.stall_cnt);
                end
            end
            cyc();
        end
        clear_inputs(); #1; checks++;
        if (obs() !== 7'b0 || b.stall_cnt !== 32'd8) begin
            errors++; $display("FAIL div_end: got %b cnt %0d want %b cnt 8", obs(), b.stall_cnt, 7'b0);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_in(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0); #1; checks++;
        if (obs() !== 7'b0001100) begin
            errors++; $display("FAIL br_prio: got %b want %b", obs(), 7'b0001100);
        end
        cyc();
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0); #1; checks++;
        if (obs() !== 7'b0001000) begin
            errors++; $display("FAIL jump_only: got %b want %b", obs(), 7'b0001000);
        end
        cyc();
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0); #1; checks++;
        if (obs() !== 7'b0001100) begin
            errors++; $display("FAIL br_only: got %b want %b", obs(), 7'b0001100);
        end
        cyc();
        clear_inputs(); #1; checks++;
        if (b.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL br_cnt: got %0d want 0", b.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [6:0] exp;
        do_reset();
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1); #1; checks++;
        if (obs() !== 7'b1110010) begin
            errors++; $display("FAIL rmd_start: got %b want %b", obs(), 7'b1110010);
        end
        cyc();
        cyc(); checks++;
        if (obs() !== 7'b1110000) begin
            errors++; $display("FAIL rmd_c2: got %b want %b", obs(), 7'b1110000);
        end
        nrst = 1'b0;
        cyc();
        nrst = 1'b1; #1; checks++;
        if (obs() !== 7'b0 || b.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rmd_quiet: got %b cnt %0d want %b cnt 0", obs(), b.stall_cnt, 7'b0);
        end
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c == 0)      exp = 7'b1110010;
            else if (c == 4) exp = 7'b0000001;
            else             exp = 7'b1110000;
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL rmd_seq%0d: got %b want %b", c, obs(), exp);
            end
        end
        checks++;
        if (b.stall_cnt !== 32'd4) begin
            errors++; $display("FAIL rmd_cnt: got %0d want 4", b.stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        s.exe_is_load = 1;  s.exe_wr_en = 1;  s.exe_rd = 5'd3;  s.id_rs1 = 5'd3;  s.id_use_rs1 = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 3 || i == 7 || i == 9) begin
                checks++;
                if (s.stall_cnt !== ((i == 3) ? 3'd3 : 3'd7)) begin
                    errors++; $display("FAIL sat_i%0d: got %0d want %0d", i, s.stall_cnt, (i == 3) ? 3 : 7);
                end
            end
            cyc();
        end
        clear_inputs();
        cyc(); checks++;
        if (s.stall_cnt !== 3'd7) begin
            errors++; $display("FAIL sat_hold: got %0d want 7", s.stall_cnt);
        end
    endtask

    initial begin
        nrst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_reset_mid_div();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
